// File: rtl/move_ctrl.sv
// Direction-button front end for the snake model: press detection, reversal and
// no-op filtering, a 2-deep turn queue, and a speed-scaled movement step strobe.
module move_ctrl #(
    parameter int unsigned STEP_BASE = 25_000_000,
    parameter int unsigned STEP_DEC  = 2_500_000,
    parameter int unsigned STEP_MIN  = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       run,
    input  logic [2:0] speed_lvl,
    output logic       step,
    output logic [1:0] dir,
    output logic [1:0] q_level
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DIFF_W = 33;
    localparam int unsigned DIR_W  = 2;
    localparam int unsigned BTN_W  = 4;
    localparam int unsigned QCNT_W = 2;

    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b00;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_UP    = 2'b10;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;

    localparam logic [QCNT_W-1:0] Q_EMPTY = 2'd0;
    localparam logic [QCNT_W-1:0] Q_ONE   = 2'd1;
    localparam logic [QCNT_W-1:0] Q_FULL  = 2'd2;

    // Button vector order: {up, down, left, right}
    logic [BTN_W-1:0]  btn_now;
    logic [BTN_W-1:0]  btn_prev_q;
    logic [BTN_W-1:0]  press;

    logic              cand_vld;
    logic [DIR_W-1:0]  cand;
    logic [DIR_W-1:0]  ref_dir;
    logic [DIR_W-1:0]  ref_opp;
    logic              push;
    logic              pop;

    logic [DIR_W-1:0]  qe0_q, qe0_d;
    logic [DIR_W-1:0]  qe1_q, qe1_d;
    logic [QCNT_W-1:0] qcnt_q, qcnt_d;
    logic [QCNT_W-1:0] wr_idx;

    logic [DIR_W-1:0]  dir_q, dir_d;
    logic              step_q, step_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  per_calc;
    logic [CNT_W-1:0]  per_eff;
    logic signed [DIFF_W-1:0] per_diff;
    logic              wrap;

    assign btn_now = {up, down, left, right};
    assign press   = btn_now & ~btn_prev_q;

    // Single candidate per cycle, priority up > down > left > right
    always_comb begin
        cand_vld = |press;
        cand     = DIR_RIGHT;
        if (press[3]) begin
            cand = DIR_UP;
        end else if (press[2]) begin
            cand = DIR_DOWN;
        end else if (press[1]) begin
            cand = DIR_LEFT;
        end
    end

    // Signed period so a large speed level clamps instead of wrapping
    always_comb begin
        per_diff = $signed(DIFF_W'(STEP_BASE))
                 - $signed(DIFF_W'(speed_lvl)) * $signed(DIFF_W'(STEP_DEC));
        if (per_diff < $signed(DIFF_W'(STEP_MIN))) begin
            per_calc = CNT_W'(STEP_MIN);
        end else begin
            per_calc = per_diff[CNT_W-1:0];
        end
    end

    // Step counter; the period in force is re-latched whenever the counter sits at 0
    always_comb begin
        per_eff = (cnt_q == '0) ? per_calc : per_q;
        per_d   = per_eff;
        wrap    = run && (cnt_q == (per_eff - CNT_W'(1)));
        step_d  = wrap;
        if (!run) begin
            cnt_d = cnt_q;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Push filtering against the newest queued heading (pre-pop state)
    always_comb begin
        unique case (qcnt_q)
            Q_EMPTY: ref_dir = dir_q;
            Q_ONE:   ref_dir = qe0_q;
            default: ref_dir = qe1_q;
        endcase
        ref_opp = ref_dir ^ DIR_LEFT;
        push    = cand_vld && (cand != ref_dir) && (cand != ref_opp) && (qcnt_q != Q_FULL);
        pop     = wrap && (qcnt_q != Q_EMPTY);
    end

    // Queue update: pop shifts the tail forward, push lands after the surviving entries
    always_comb begin
        qe0_d  = qe0_q;
        qe1_d  = qe1_q;
        dir_d  = dir_q;
        wr_idx = qcnt_q - QCNT_W'(pop);
        if (pop) begin
            dir_d = qe0_q;
            qe0_d = qe1_q;
        end
        if (push) begin
            if (wr_idx == Q_EMPTY) begin
                qe0_d = cand;
            end else begin
                qe1_d = cand;
            end
        end
        qcnt_d = qcnt_q + QCNT_W'(push) - QCNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q <= btn_now;
            qe0_q      <= DIR_RIGHT;
            qe1_q      <= DIR_RIGHT;
            qcnt_q     <= Q_EMPTY;
            dir_q      <= DIR_RIGHT;
            step_q     <= 1'b0;
            cnt_q      <= '0;
            per_q      <= per_calc;
        end else begin
            btn_prev_q <= btn_now;
            qe0_q      <= qe0_d;
            qe1_q      <= qe1_d;
            qcnt_q     <= qcnt_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
        end
    end

    assign step    = step_q;
    assign dir     = dir_q;
    assign q_level = qcnt_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: directed scenarios plus random button/run/speed traffic,
// all compared against a queue-based behavioural model of the turn logic and step timing.
module tb_move_ctrl;

    localparam int unsigned SB = 10;
    localparam int unsigned SD = 2;
    localparam int unsigned SM = 4;

    logic       clk = 1'b0;
    logic       reset, left, right, up, down, run;
    logic [2:0] speed_lvl;
    logic       step;
    logic [1:0] dir, q_level;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] m_prev;
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    int         m_rem;
    logic       m_step;

    always #5 clk = ~clk;

    move_ctrl #(.STEP_BASE(SB), .STEP_DEC(SD), .STEP_MIN(SM)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
        .run(run), .speed_lvl(speed_lvl), .step(step), .dir(dir), .q_level(q_level)
    );

    function automatic int period_of(input int lvl);
        int p;
        p = int'(SB) - lvl * int'(SD);
        if (p < int'(SM)) p = int'(SM);
        return p;
    endfunction

    function automatic logic [1:0] opposite_of(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        logic [3:0] lv, press;
        logic [1:0] cand, refd;
        logic       has, accept;
        lv = {up, down, left, right};
        if (reset) begin
            m_prev = lv;
            m_q.delete();
            m_dir  = 2'b00;
            m_rem  = 0;
            m_step = 1'b0;
            return;
        end
        press  = lv & ~m_prev;
        m_prev = lv;
        has    = (press != 4'b0000);
        if (press[3])      cand = 2'b10;
        else if (press[2]) cand = 2'b11;
        else if (press[1]) cand = 2'b01;
        else               cand = 2'b00;
        refd   = (m_q.size() > 0) ? m_q[$] : m_dir;
        accept = has && (cand != refd) && (cand != opposite_of(refd)) && (m_q.size() < 2);
        m_step = 1'b0;
        if (run) begin
            if (m_rem == 0) m_rem = period_of(int'(speed_lvl));
            m_rem--;
            if (m_rem == 0) m_step = 1'b1;
        end
        if (m_step && m_q.size() > 0) m_dir = m_q.pop_front();
        if (accept) m_q.push_back(cand);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("step", 32'(step), 32'(m_step));
        check("dir", 32'(dir), 32'(m_dir));
        check("q_level", 32'(q_level), 32'(m_q.size()));
    endtask

    task automatic set_btn(input logic [3:0] b);
        {up, down, left, right} = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; speed_lvl = 3'd0;
        set_btn(4'b0000);
        tick();
        tick();
        check("reset_step", 32'(step), 32'd0);
        check("reset_dir", 32'(dir), 32'd0);
        check("reset_qlevel", 32'(q_level), 32'd0);

        // Basic cadence
        reset = 1'b0; run = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            check("cadence_step", 32'(step), 32'((i % 10) == 0));
            check("cadence_dir", 32'(dir), 32'd0);
        end

        // Single turn
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            set_btn((i == 4) ? 4'b1000 : 4'b0000);
            tick();
            if (i == 4) check("turn_qlevel", 32'(q_level), 32'd1);
        end
        check("turn_dir", 32'(dir), 32'd2);
        check("turn_qempty", 32'(q_level), 32'd0);

        // Reversal and no-op rejection
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            set_btn((i == 2) ? 4'b0010 : (i == 4) ? 4'b0001 : 4'b0000);
            tick();
            check("reject_qlevel", 32'(q_level), 32'd0);
        end
        check("reject_dir", 32'(dir), 32'd0);

        // Double-tap and overflow
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            set_btn((i == 2) ? 4'b1000 : (i == 4) ? 4'b0010 : (i == 6) ? 4'b0100 : 4'b0000);
            tick();
            if (i == 6) check("dtap_full", 32'(q_level), 32'd2);
            if (i == 10) begin
                check("dtap_dir1", 32'(dir), 32'd2);
                check("dtap_q1", 32'(q_level), 32'd1);
            end
        end
        check("dtap_dir2", 32'(dir), 32'd1);
        check("dtap_q2", 32'(q_level), 32'd0);

        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_btn((i == 2) ? 4'b1000 : (i == 4) ? 4'b0100 : 4'b0000);
            tick();
        end
        check("opp_tail_drop", 32'(q_level), 32'd1);

        // Simultaneous buttons
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            set_btn((i == 2) ? 4'b1010 : 4'b0000);
            tick();
            if (i == 2) check("simul_qlevel", 32'(q_level), 32'd1);
        end
        check("simul_dir", 32'(dir), 32'd2);

        set_btn(4'b0100);
        do_reset();
        for (int i = 1; i <= 5; i++) tick();
        check("held_reset", 32'(q_level), 32'd0);
        set_btn(4'b0000);

        // Speed clamp, pause, mid-period speed change
        speed_lvl = 3'd5;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            run       = !(i >= 15 && i <= 21);
            speed_lvl = (i >= 25) ? 3'd0 : 3'd5;
            tick();
            check("speed_step", 32'(step),
                  32'(i == 4 || i == 8 || i == 12 || i == 23 || i == 27 || i == 37));
        end

        // Random traffic
        run = 1'b1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) up    = ~up;
            if ($urandom_range(0, 4) == 0) down  = ~down;
            if ($urandom_range(0, 4) == 0) left  = ~left;
            if ($urandom_range(0, 4) == 0) right = ~right;
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) speed_lvl = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_ctrl.md
# move_ctrl

Converts the four debounced direction buttons into a validated, queued heading and a periodic step strobe for the snake game model. Sits between the debounce stages and `snake_model`. It rejects reversals and no-op presses, buffers up to two turns so quick double-taps are not lost, and generates the movement tick whose rate scales with a speed level.

## Interface

Parameters:

- `STEP_BASE`, default 25_000_000: step period in clocks at speed level 0.
- `STEP_DEC`, default 2_500_000: period reduction per speed level.
- `STEP_MIN`, default 5_000_000: lower clamp on the step period.

Ports:

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `left`  in  1  debounced button level.
- `right`  in  1  debounced button level.
- `up`  in  1  debounced button level.
- `down`  in  1  debounced button level.
- `run`  in  1  game running; 0 freezes stepping.
- `speed_lvl`  in  3  speed level, 0..7.
- `step`  out  1  one-cycle movement strobe.
- `dir`  out  2  current heading: 00 right, 01 left, 10 up, 11 down.
- `q_level`  out  2  turn-queue occupancy, 0..2.

## Operation

- **Edge detect.**
  - Each button has a previous-level register; press = level & ~prev.
  - During reset, prev loads the live input, so a button held through reset produces no press.
- **Simultaneous presses.**
  - If several presses occur in the same cycle, only one is a candidate.
  - Priority is up > down > left > right.
- **Reference direction.**
  - The reference is the newest queue entry if the queue is non-empty, otherwise `dir`.
  - It is evaluated on pre-pop state.
- **Push rules.**
  - Candidate equal to the reference: drop.
  - Candidate opposite to the reference (right/left, up/down): drop.
  - Queue count == 2 (pre-pop): drop, even if a pop occurs in the same cycle.
  - Otherwise the candidate is written to the queue tail.
- **Queue.** 2-entry FIFO, 2-bit entries; `q_level` = count.
- **Step counter.**
  - 32-bit unsigned counter, incrementing only while `run`=1.
  - Period P = max(STEP_MIN, STEP_BASE − speed_lvl·STEP_DEC). The subtraction is computed signed 33-bit so that underflow clamps to STEP_MIN.
  - P is latched when the counter is 0; a `speed_lvl` change takes effect from the next period.
  - When the counter reaches P−1 with `run`=1: the counter returns to 0 and `step` is registered high for one cycle.
- **Pop.**
  - On the edge that asserts `step`, if count > 0, `dir` takes the queue head and the head is popped.
  - A consumer sampling `dir` while `step`=1 therefore sees the new heading.
  - Push and pop in the same cycle are both performed.
- **Pause.**
  - While `run`=0: the counter holds its value, `step` stays 0, and presses are still queued.
  - Counting resumes from the held value when `run` returns to 1.

## Timing

- **Reset values:** `dir`=00, `q_level`=0, `step`=0, counter=0, queue empty, latched P = P(speed_lvl at reset).
- **Press latency:** a rising input sampled at edge k gives an updated `q_level` after edge k (1 cycle).
- **Step cadence:** with `run`=1 continuously after reset release, the first `step` is high during the P-th cycle, then every P cycles. `step` is never high for 2 consecutive cycles unless P=1, which is not a legal configuration (STEP_MIN ≥ 2).
- **Reset mid-operation:** all state returns to reset values on the next edge; a pending step is discarded.

## Test plan

Use STEP_BASE=10, STEP_DEC=2, STEP_MIN=4.

1. **Basic cadence.** Reset, then `run`=1, `speed_lvl`=0, no presses → `step` pulses at cycles 10, 20, 30 after release; `dir` stays 00; `q_level` stays 0.
2. **Single turn.** Pulse `up` at cycle 3 → `q_level`=1 from cycle 4; at the cycle-10 step, `dir`=10 and `q_level`=0.
3. **Reversal and no-op rejection.** With `dir`=00 and the queue empty, press `left` → `q_level` stays 0. Press `right` → `q_level` stays 0. At the next step, `dir` is still 00.
4. **Double-tap and overflow.**
   - Press `up`, `left`, `down` on separate cycles before a step → `q_level`=2; the third press is dropped.
   - First step → `dir`=10, `q_level`=1. Second step → `dir`=01, `q_level`=0.
   - Separately, with the queue at [up], press `down` → dropped (opposite of tail).
5. **Simultaneous buttons.**
   - `up` and `left` rise in the same cycle → only `up` is queued; `q_level`=1.
   - Holding `down` through reset → no press after release.
6. **Speed and pause.**
   - `speed_lvl`=5 (10−10 → clamp) → `step` every 4 cycles.
   - Drop `run` for 7 cycles mid-period → no step, counter frozen; the step then fires after the remaining cycles of that period.
   - Change `speed_lvl` mid-period → the old P completes first.
